// File: rtl/i2c_target.sv
// -----------------------------------------------------------------------------
// i2c_target
//   I2C target (slave) with a 16 x 8-bit register file. A write transaction
//   loads the register pointer from the first data byte (low nibble only); each
//   further byte is stored at the pointer, which then increments. A read
//   transaction returns regs[pointer] and increments after every byte. The
//   pointer wraps 15 -> 0 and persists across transactions.
//
//   Handshake: there is no valid/ready pair. wr_pulse_o is a single-cycle
//   strobe, and wr_idx_o plus the updated regs_o byte are valid in that cycle.
//
//   Optional build macro: I2C_TARGET_GLITCH_FILTER_EN
//     defined   : a synchronised SCL/SDA level is accepted only after it has been
//                 stable for 3 consecutive clk_sys_i cycles.
//     undefined : the synchronised signals are used directly.
//
// Ports
//   clk_sys_i   system clock, all state on its rising edge
//   rst_sys_ni  asynchronous active-low reset
//   scl_i/sda_i raw pad inputs (asynchronous)
//   sda_o       SDA drive value, always 0 (open drain)
//   sda_en_o    1 = pull SDA low
//   regs_o      register file, byte n at [8n+7:8n]
//   wr_pulse_o  one-cycle strobe per register byte written
//   wr_idx_o    index of the written register, valid with wr_pulse_o
//   busy_o      1 while an addressed transaction is in progress
//   dbg_state   current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module i2c_target #(
   parameter logic [6:0] TargetAddr = 7'h50
) (
   input  logic         clk_sys_i,
   input  logic         rst_sys_ni,
   input  logic         scl_i,
   input  logic         sda_i,
   output logic         sda_o,
   output logic         sda_en_o,
   output logic [127:0] regs_o,
   output logic         wr_pulse_o,
   output logic [3:0]   wr_idx_o,
   output logic         busy_o,
   output logic [2:0]   dbg_state
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
   } state_t;

   // ---------------------------------------------------------------------------
   // Input conditioning: 2-flop synchronisers, reset to the idle bus level (1)
   // ---------------------------------------------------------------------------
   logic [1:0] scl_sync;
   logic [1:0] sda_sync;

   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
      end else begin
         scl_sync <= {scl_sync[0], scl_i};
         sda_sync <= {sda_sync[0], sda_i};
      end
   end

   logic scl_s;
   logic sda_s;

`ifdef I2C_TARGET_GLITCH_FILTER_EN
   // A level is taken only once the last three synchronised samples agree.
   logic [2:0] scl_hist;
   logic [2:0] sda_hist;

   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         scl_hist <= 3'b111;
         sda_hist <= 3'b111;
         scl_s    <= 1'b1;
         sda_s    <= 1'b1;
      end else begin
         scl_hist <= {scl_hist[1:0], scl_sync[1]};
         sda_hist <= {sda_hist[1:0], sda_sync[1]};
         if (scl_hist == 3'b111)      scl_s <= 1'b1;
         else if (scl_hist == 3'b000) scl_s <= 1'b0;
         if (sda_hist == 3'b111)      sda_s <= 1'b1;
         else if (sda_hist == 3'b000) sda_s <= 1'b0;
      end
   end
`else
   assign scl_s = scl_sync[1];
   assign sda_s = sda_sync[1];
`endif

   // ---------------------------------------------------------------------------
   // Bus event detection
   // ---------------------------------------------------------------------------
   logic scl_prev;
   logic sda_prev;

   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_prev <= scl_s;
         sda_prev <= sda_s;
      end
   end

   logic scl_rise;
   logic scl_fall;
   logic start_det;
   logic stop_det;

   // START/STOP need SCL high on both samples so an SCL edge is never mistaken
   // for an SDA transition.
   assign scl_rise  = scl_s & ~scl_prev;
   assign scl_fall  = ~scl_s & scl_prev;
   assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
   assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

   // ---------------------------------------------------------------------------
   // Protocol FSM and register file
   // ---------------------------------------------------------------------------
   state_t       state;
   logic [3:0]   bit_cnt;
   logic [7:0]   shreg;
   logic [3:0]   ptr;
   logic         rw;
   logic         first_byte;
   logic         rd_acked;
   logic [127:0] regs_q;

   logic [7:0] shift_in;
   logic [7:0] rd_byte;

   assign shift_in = {shreg[6:0], sda_s};
   assign rd_byte  = regs_q[{ptr, 3'b000} +: 8];

   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         state      <= IDLE;
         bit_cnt    <= 4'd0;
         shreg      <= 8'd0;
         ptr        <= 4'd0;
         rw         <= 1'b0;
         first_byte <= 1'b0;
         rd_acked   <= 1'b0;
         regs_q     <= '0;
         sda_en_o   <= 1'b0;
         wr_pulse_o <= 1'b0;
         wr_idx_o   <= 4'd0;
      end else begin
         wr_pulse_o <= 1'b0;
         if (stop_det) begin
            state    <= IDLE;
            sda_en_o <= 1'b0;
            bit_cnt  <= 4'd0;
         end else if (start_det) begin
            state    <= ADDR;
            sda_en_o <= 1'b0;
            bit_cnt  <= 4'd0;
         end else begin
            case (state)
               IDLE, IGNORE: ;
               ADDR: begin
                  if (scl_rise) begin
                     shreg   <= shift_in;
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall && bit_cnt == 4'd8) begin
                     if (shreg[7:1] == TargetAddr) begin
                        state    <= ADDR_ACK;
                        rw       <= shreg[0];
                        sda_en_o <= 1'b1;
                     end else begin
                        state <= IGNORE;
                     end
                  end
               end
               ADDR_ACK: begin
                  // This falling edge ends the ACK; a read drives its MSB here.
                  if (scl_fall) begin
                     if (rw) begin
                        shreg    <= rd_byte;
                        sda_en_o <= ~rd_byte[7];
                        bit_cnt  <= 4'd1;
                        state    <= RD_BYTE;
                     end else begin
                        sda_en_o   <= 1'b0;
                        bit_cnt    <= 4'd0;
                        first_byte <= 1'b1;
                        state      <= WR_BYTE;
                     end
                  end
               end
               WR_BYTE: begin
                  if (scl_rise) begin
                     shreg   <= shift_in;
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt == 4'd7) begin
                        if (first_byte) begin
                           ptr        <= shift_in[3:0];
                           first_byte <= 1'b0;
                        end else begin
                           regs_q[{ptr, 3'b000} +: 8] <= shift_in;
                           wr_pulse_o <= 1'b1;
                           wr_idx_o   <= ptr;
                           ptr        <= ptr + 4'd1;
                        end
                     end
                  end else if (scl_fall && bit_cnt == 4'd8) begin
                     sda_en_o <= 1'b1;
                     state    <= WR_ACK;
                  end
               end
               WR_ACK: begin
                  if (scl_fall) begin
                     sda_en_o <= 1'b0;
                     bit_cnt  <= 4'd0;
                     state    <= WR_BYTE;
                  end
               end
               RD_BYTE: begin
                  // bit_cnt counts bits already placed on the bus.
                  if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        sda_en_o <= 1'b0;
                        ptr      <= ptr + 4'd1;
                        bit_cnt  <= 4'd0;
                        rd_acked <= 1'b0;
                        state    <= RD_ACK;
                     end else begin
                        sda_en_o <= ~shreg[6];
                        shreg    <= {shreg[6:0], 1'b0};
                        bit_cnt  <= bit_cnt + 4'd1;
                     end
                  end
               end
               RD_ACK: begin
                  if (scl_rise) begin
                     if (sda_s) state <= IGNORE;
                     else       rd_acked <= 1'b1;
                  end else if (scl_fall && rd_acked) begin
                     shreg    <= rd_byte;
                     sda_en_o <= ~rd_byte[7];
                     bit_cnt  <= 4'd1;
                     state    <= RD_BYTE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign sda_o     = 1'b0;
   assign regs_o    = regs_q;
   assign dbg_state = state;
   assign busy_o    = (state == ADDR_ACK) || (state == WR_BYTE) || (state == WR_ACK) ||
                      (state == RD_BYTE)  || (state == RD_ACK);

endmodule

// File: tb/tb_i2c_target.sv
// -----------------------------------------------------------------------------
// tb_i2c_target
//   Bench for i2c_target. An I2C controller model drives the bus; the target's
//   open-drain drive is merged onto SDA. A transaction-level model (register
//   array + pointer) predicts ACKs, read data and register writes. Expected
//   writes go into exp_q and are popped by a monitor on every wr_pulse_o.
// -----------------------------------------------------------------------------
module tb_i2c_target;

   localparam logic [6:0] TGT = 7'h50;
   localparam int         Q   = 10;   // quarter SCL period in clk cycles

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- bus ----------------
   logic scl_drv    = 1'b1;
   logic scl_glitch = 1'b0;
   logic sda_ctrl   = 1'b1;

   logic         sda_o;
   logic         sda_en;
   logic [127:0] regs;
   logic         wr_pulse;
   logic [3:0]   wr_idx;
   logic         busy;
   logic [2:0]   dbg_state;

   wire scl_line = scl_drv | scl_glitch;
   wire sda_line = sda_ctrl & ~sda_en;

   i2c_target #(.TargetAddr(TGT)) dut (
      .clk_sys_i (clk),
      .rst_sys_ni(rst_n),
      .scl_i     (scl_line),
      .sda_i     (sda_line),
      .sda_o     (sda_o),
      .sda_en_o  (sda_en),
      .regs_o    (regs),
      .wr_pulse_o(wr_pulse),
      .wr_idx_o  (wr_idx),
      .busy_o    (busy),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard / model ----------------
   int          n_cmp = 0;
   int          n_err = 0;
   logic [11:0] exp_q[$];         // {index, data} of expected register writes
   logic [7:0]  m_regs[16];
   logic [3:0]  m_ptr;
   logic [7:0]  wbuf[8];
   logic        quiet_mon = 1'b0;
   int          viol = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // write monitor
   always @(negedge clk) begin
      if (rst_n && wr_pulse) begin
         if (exp_q.size() == 0) begin
            check("wr_pulse_expected", 32'd0, 32'd1);
         end else begin
            logic [11:0] e;
            e = exp_q.pop_front();
            check("wr_idx_data", {20'd0, wr_idx, regs[{wr_idx, 3'b000} +: 8]}, {20'd0, e});
         end
      end
   end

   // non-addressed traffic must never drive SDA or raise busy
   always @(negedge clk) begin
      if (quiet_mon && (sda_en || busy)) viol <= viol + 1;
   end

   // ---------------- driver tasks ----------------
   task automatic qw();
      repeat (Q) @(posedge clk);
   endtask

   task automatic bus_start();
      sda_ctrl = 1'b1; qw();
      scl_drv  = 1'b1; qw();
      sda_ctrl = 1'b0; qw();
      scl_drv  = 1'b0; qw();
   endtask

   task automatic bus_stop();
      sda_ctrl = 1'b0; qw();
      scl_drv  = 1'b1; qw();
      sda_ctrl = 1'b1; qw();
   endtask

   task automatic send_bit(input logic b, input bit glitch);
      sda_ctrl = b;
      if (glitch) begin
         repeat (3) @(posedge clk);
         scl_glitch = 1'b1;
         @(posedge clk);
         scl_glitch = 1'b0;
         repeat (Q - 4) @(posedge clk);
      end else begin
         qw();
      end
      scl_drv = 1'b1; qw(); qw();
      scl_drv = 1'b0; qw();
   endtask

   task automatic recv_bit(output logic b);
      sda_ctrl = 1'b1; qw();
      scl_drv  = 1'b1; qw();
      b = sda_line;    qw();
      scl_drv  = 1'b0; qw();
   endtask

   task automatic write_byte(input logic [7:0] d, input int glitch_bit, output bit ack);
      logic b;
      for (int i = 7; i >= 0; i--) send_bit(d[i], i == glitch_bit);
      recv_bit(b);
      ack = !b;
   endtask

   task automatic read_byte(output logic [7:0] d, input bit ack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(b);
         d[i] = b;
      end
      send_bit(!ack, 1'b0);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
      m_ptr = 4'd0;
   endtask

   // Write transaction of n bytes from wbuf to address a.
   task automatic do_write(input logic [6:0] a, input int n, input bit do_stop);
      bit ack;
      bit hit;
      int v0;
      hit       = (a == TGT);
      v0        = viol;
      quiet_mon = !hit;
      bus_start();
      write_byte({a, 1'b0}, -1, ack);
      check("addr_ack_w", {31'd0, ack}, {31'd0, hit});
      if (hit) check("busy_mid_w", {31'd0, busy}, 32'd1);
      for (int i = 0; i < n; i++) begin
         if (hit) begin
            if (i == 0) begin
               m_ptr = wbuf[0][3:0];
            end else begin
               exp_q.push_back({m_ptr, wbuf[i]});
               m_regs[m_ptr] = wbuf[i];
               m_ptr = m_ptr + 4'd1;
            end
         end
         write_byte(wbuf[i], -1, ack);
         check("data_ack", {31'd0, ack}, {31'd0, hit});
      end
      if (do_stop) begin
         bus_stop();
         check("busy_after_stop", {31'd0, busy}, 32'd0);
      end
      quiet_mon = 1'b0;
      @(posedge clk);
      if (!hit) check("quiet_bus", viol - v0, 32'd0);
   endtask

   // (Repeated) START, read address, n bytes: ACK all but the last, then STOP.
   task automatic do_read(input int n);
      bit         ack;
      logic [7:0] d;
      logic [7:0] e;
      bus_start();
      write_byte({TGT, 1'b1}, -1, ack);
      check("addr_ack_r", {31'd0, ack}, 32'd1);
      for (int i = 0; i < n; i++) begin
         e     = m_regs[m_ptr];
         m_ptr = m_ptr + 4'd1;
         read_byte(d, i != n - 1);
         check("rd_data", {24'd0, d}, {24'd0, e});
      end
      check("sda_released_nack", {31'd0, sda_en}, 32'd0);
      bus_stop();
      check("busy_after_rd", {31'd0, busy}, 32'd0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      repeat (150000) @(posedge clk);
      $display("FAIL watchdog: run did not complete, expected finish within 150000 cycles");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin
      bit         ack;
      logic       b;
      logic [6:0] a;
      logic [7:0] gexp;
      bit         gack;
      model_reset();

      // reset state
      repeat (4) @(posedge clk);
      #1;
      check("rst_sda_en",   {31'd0, sda_en},   32'd0);
      check("rst_wr_pulse", {31'd0, wr_pulse}, 32'd0);
      check("rst_wr_idx",   {28'd0, wr_idx},   32'd0);
      check("rst_busy",     {31'd0, busy},     32'd0);
      check("rst_regs_zero", {31'd0, (regs == 128'd0)}, 32'd1);
      check("sda_o_const",  {31'd0, sda_o},    32'd0);
      rst_n = 1'b1;
      repeat (10) @(posedge clk);

      // write 03 AB CD
      wbuf[0] = 8'h03; wbuf[1] = 8'hAB; wbuf[2] = 8'hCD;
      do_write(TGT, 3, 1'b1);

      // pointer 03, repeated START, read two bytes
      wbuf[0] = 8'h03;
      do_write(TGT, 1, 1'b0);
      do_read(2);

      // wrong address: no ACK, quiet bus
      wbuf[0] = 8'h55;
      do_write(7'h51, 1, 1'b1);

      // pointer wrap 15 -> 0, then read at pointer 1
      wbuf[0] = 8'hF1; wbuf[1] = 8'h77;   // upper nibble of pointer byte ignored
      do_write(TGT, 2, 1'b1);
      wbuf[0] = 8'h0F; wbuf[1] = 8'h11; wbuf[2] = 8'h22;
      do_write(TGT, 3, 1'b1);
      do_read(1);

      // reset while the target is pulling SDA during a read of 0xAB
      wbuf[0] = 8'h03;
      do_write(TGT, 1, 1'b0);
      bus_start();
      write_byte({TGT, 1'b1}, -1, ack);
      check("addr_ack_r_rst", {31'd0, ack}, 32'd1);
      recv_bit(b);
      check("rd_bit7_rst", {31'd0, b}, 32'd1);
      check("sda_en_before_rst", {31'd0, sda_en}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("sda_en_async_rst", {31'd0, sda_en}, 32'd0);
      check("regs_zero_rst", {31'd0, (regs == 128'd0)}, 32'd1);
      check("busy_rst", {31'd0, busy}, 32'd0);
      model_reset();
      repeat (5) @(posedge clk);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      bus_stop();
      wbuf[0] = 8'h02; wbuf[1] = 8'h5A; wbuf[2] = 8'hA5;
      do_write(TGT, 3, 1'b1);
      wbuf[0] = 8'h02;
      do_write(TGT, 1, 1'b0);
      do_read(2);

      // single-cycle SCL glitch before the MSB of a data byte
`ifdef I2C_TARGET_GLITCH_FILTER_EN
      gexp = 8'h5A; gack = 1'b1;
`else
      gexp = 8'h2D; gack = 1'b0;          // MSB sampled twice, LSB lost
`endif
      bus_start();
      write_byte({TGT, 1'b0}, -1, ack);
      check("addr_ack_g", {31'd0, ack}, 32'd1);
      write_byte(8'h05, -1, ack);
      check("ptr_ack_g", {31'd0, ack}, 32'd1);
      exp_q.push_back({4'd5, gexp});
      m_regs[5] = gexp;
      m_ptr     = 4'd6;
      write_byte(8'h5A, 7, ack);
      check("glitch_ack", {31'd0, ack}, {31'd0, gack});
      bus_stop();

      // randomized transactions
      for (int it = 0; it < 10; it++) begin
         int r;
         int n;
         r = $urandom_range(0, 3);
         if (r == 0) begin
            a = 7'($urandom_range(0, 127));
            if (a == TGT) a = a ^ 7'd1;
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom_range(0, 255));
            do_write(a, n, 1'b1);
         end else if (r == 3) begin
            wbuf[0] = 8'($urandom_range(0, 255));
            do_write(TGT, 1, 1'b0);
            do_read($urandom_range(1, 3));
         end else begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom_range(0, 255));
            do_write(TGT, n, 1'b1);
         end
      end

      // final state
      repeat (5) @(posedge clk);
      for (int i = 0; i < 16; i++)
         check($sformatf("final_reg%0d", i), {24'd0, regs[i*8 +: 8]}, {24'd0, m_regs[i]});
      check("exp_q_drained", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
